gf180mcu_fd_sc_mcu9t5v0__or_agg: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg_pkg.sv | 16 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg_bit.sv | 46 ++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg.sv | 83 ++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__or_agg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg_pkg.sv
// Shared types for the masked OR event aggregator.
// Mode encodings and clear-handshake FSM states.
package gf180mcu_fd_sc_mcu9t5v0__or_agg_pkg;

   typedef enum logic [1:0] {
      MODE_LEVEL       = 2'b00,
      MODE_STICKY_LVL  = 2'b01,
      MODE_STICKY_EDGE = 2'b10
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } clr_state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg_bit.sv
// One input slice: delayed input, edge detect and flag.
// Mode 11 falls through to plain level behaviour.
module gf180mcu_fd_sc_mcu9t5v0__or_agg_bit
   import gf180mcu_fd_sc_mcu9t5v0__or_agg_pkg::*;
(
   input  logic       clk,
   input  logic       rn,
   input  logic       a,
   input  logic       mask,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       flag,
   output logic       flag_d,
   output logic       rise
);

   logic a_q;
   logic lvl;
   logic held;

   assign lvl  = a & mask;
   assign rise = a & ~a_q & mask;
   assign held = clr ? 1'b0 : flag;

   // next flag value: set terms are OR-ed after clear, so set wins
   always_comb begin
      flag_d = lvl;
      unique case (1'b1)
         (mode == MODE_STICKY_LVL):  flag_d = held | lvl;
         (mode == MODE_STICKY_EDGE): flag_d = held | rise;
         default:                    flag_d = lvl;
      endcase
   end

   // input history and flag register
   always_ff @(posedge clk) begin
      if (!rn) begin
         a_q  <= 1'b0;
         flag <= 1'b0;
      end else begin
         a_q  <= a;
         flag <= flag_d;
      end
   end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__or_agg.sv
// Masked OR aggregator: per-input flags, registered OR,
// saturating edge counter and req/ack clear handshake.
module gf180mcu_fd_sc_mcu9t5v0__or_agg
   import gf180mcu_fd_sc_mcu9t5v0__or_agg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNTW  = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] MASK,
   input  logic [1:0]       MODE,
   input  logic             CLR_REQ,
   output logic             CLR_ACK,
   output logic [WIDTH-1:0] FLAGS,
   output logic             Z,
   output logic [CNTW-1:0]  CNT,
   inout  wire              VDD,
   inout  wire              VSS
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   clr_state_e       state;
   clr_state_e       state_n;
   logic             clr;
   logic             any_rise;
   logic [WIDTH-1:0] flags_d;
   logic [WIDTH-1:0] rise;
   logic             unused_supply;

   assign unused_supply = VDD ^ VSS;

   assign clr      = (state == IDLE) && CLR_REQ;
   assign any_rise = |rise;
   assign CLR_ACK  = (state == ACK);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gf180mcu_fd_sc_mcu9t5v0__or_agg_bit u_bit (
         .clk    (CLK),
         .rn     (RN),
         .a      (A[i]),
         .mask   (MASK[i]),
         .mode   (MODE),
         .clr    (clr),
         .flag   (FLAGS[i]),
         .flag_d (flags_d[i]),
         .rise   (rise[i])
      );
   end

   // clear handshake state register
   always_ff @(posedge CLK) begin
      if (!RN) state <= IDLE;
      else     state <= state_n;
   end

   // one clear per request: IDLE accepts, ACK waits for req drop
   always_comb begin
      state_n = state;
      unique case (1'b1)
         (state == IDLE): if (CLR_REQ)  state_n = ACK;
         (state == ACK):  if (!CLR_REQ) state_n = IDLE;
         default:         state_n = IDLE;
      endcase
   end

   // registered OR tree and saturating edge counter
   always_ff @(posedge CLK) begin
      if (!RN) begin
         Z   <= 1'b0;
         CNT <= '0;
      end else begin
         Z <= |flags_d;
         if (clr)
            CNT <= any_rise ? CNTW'(1) : '0;
         else if (any_rise && (CNT != CNT_MAX))
            CNT <= CNT + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__or_agg.sv
// Bench for the OR aggregator: behavioural model plus
// directed vectors with literal expectations.
module tb_gf180mcu_fd_sc_mcu9t5v0__or_agg;

   logic       clk = 1'b0;
   logic       rn;
   logic [3:0] a;
   logic [3:0] mask;
   logic [1:0] mode;
   logic       req;

   logic       ack8, ack4;
   logic [3:0] flags8, flags4;
   logic       z8, z4;
   logic [7:0] cnt8;
   logic [3:0] cnt4;
   wire        vdd = 1'b1;
   wire        vss = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu9t5v0__or_agg #(.WIDTH(4), .CNTW(8)) dut (
      .CLK(clk), .RN(rn), .A(a), .MASK(mask), .MODE(mode),
      .CLR_REQ(req), .CLR_ACK(ack8), .FLAGS(flags8), .Z(z8),
      .CNT(cnt8), .VDD(vdd), .VSS(vss)
   );

   gf180mcu_fd_sc_mcu9t5v0__or_agg #(.WIDTH(4), .CNTW(4)) dut4 (
      .CLK(clk), .RN(rn), .A(a), .MASK(mask), .MODE(mode),
      .CLR_REQ(req), .CLR_ACK(ack4), .FLAGS(flags4), .Z(z4),
      .CNT(cnt4), .VDD(vdd), .VSS(vss)
   );

   // behavioural model
   logic [3:0] m_aq, m_flags;
   logic       m_z, m_ack;
   int         m_cnt8, m_cnt4;
   bit         started = 0;

   always @(posedge clk) begin
      logic [3:0] l, e, base, nf;
      bit clear;
      if (!rn) begin
         m_aq = 0; m_flags = 0; m_z = 0;
         m_cnt8 = 0; m_cnt4 = 0; m_ack = 0;
         started = 1;
      end else begin
         l = a & mask;
         e = a & ~m_aq & mask;
         clear = req && !m_ack;
         base = clear ? 4'h0 : m_flags;
         case (mode)
            2'd1:    nf = base | l;
            2'd2:    nf = base | e;
            default: nf = l;
         endcase
         m_flags = nf;
         m_z = (nf != 0);
         if (clear) begin
            m_cnt8 = (e != 0) ? 1 : 0;
            m_cnt4 = m_cnt8;
         end else if (e != 0) begin
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
         end
         m_ack = req;
         m_aq = a;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("m_flags", 32'(flags8), 32'(m_flags));
         chk("m_z", 32'(z8), 32'(m_z));
         chk("m_ack", 32'(ack8), 32'(m_ack));
         chk("m_cnt8", 32'(cnt8), 32'(m_cnt8));
         chk("m_cnt4", 32'(cnt4), 32'(m_cnt4));
         chk("m_flags4", 32'(flags4), 32'(m_flags));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rn = 0; a = 4'hF; mask = 4'hF; mode = 2'b00; req = 0;
      cyc(2);
      chk("rst_flags", 32'(flags8), 0);
      chk("rst_z", 32'(z8), 0);
      chk("rst_cnt", 32'(cnt8), 0);
      chk("rst_ack", 32'(ack8), 0);

      // level mode
      rn = 1; a = 4'b0100;
      cyc();
      chk("lvl_flags", 32'(flags8), 32'h4);
      chk("lvl_z", 32'(z8), 1);
      chk("lvl_cnt", 32'(cnt8), 1);
      a = 4'h0;
      cyc();
      chk("lvl_flags0", 32'(flags8), 0);
      chk("lvl_z0", 32'(z8), 0);

      // sticky edge
      mode = 2'b10; mask = 4'b1011; a = 4'b0100;
      cyc();
      chk("masked_flags", 32'(flags8), 0);
      a = 4'h0; cyc();
      a = 4'b0001; cyc();
      a = 4'h0; cyc();
      chk("edge_flags", 32'(flags8), 32'h1);
      chk("edge_z", 32'(z8), 1);
      chk("edge_cnt", 32'(cnt8), 2);
      a = 4'b0010; cyc(5);
      chk("hold_cnt", 32'(cnt8), 3);
      chk("hold_flags", 32'(flags8), 32'h3);
      a = 4'h0; cyc();

      // clear handshake
      req = 1; cyc();
      chk("clr_flags", 32'(flags8), 0);
      chk("clr_ack", 32'(ack8), 1);
      chk("clr_cnt", 32'(cnt8), 0);
      a = 4'b1000; cyc();
      chk("ack_flags", 32'(flags8), 32'h8);
      chk("ack_cnt", 32'(cnt8), 1);
      cyc(2);
      chk("ack_hold", 32'(ack8), 1);
      chk("no_reclear", 32'(flags8), 32'h8);
      req = 0; a = 4'h0; cyc();
      chk("ack_drop", 32'(ack8), 0);

      // clear with simultaneous event
      mode = 2'b01; a = 4'b0010; req = 1; cyc();
      chk("set_win_flags", 32'(flags8), 32'h2);
      chk("set_win_z", 32'(z8), 1);
      chk("set_win_cnt", 32'(cnt8), 1);
      req = 0; a = 4'h0; cyc(2);
      chk("sticky_lvl", 32'(flags8), 32'h2);

      // saturation
      mode = 2'b10; mask = 4'hF;
      for (int i = 0; i < 20; i++) begin
         a = 4'b0001; cyc();
         a = 4'h0; cyc();
      end
      chk("sat_cnt4", 32'(cnt4), 15);
      chk("sat_cnt8", 32'(cnt8), 21);
      a = 4'b0001; cyc(); a = 4'h0; cyc();
      chk("sat_stay", 32'(cnt4), 15);

      // reserved mode acts as level
      mode = 2'b11; a = 4'b0001; cyc();
      chk("rsv_flags", 32'(flags8), 32'h1);
      a = 4'h0; cyc();
      chk("rsv_flags0", 32'(flags8), 0);

      // reset during ACK
      mode = 2'b10; req = 1; cyc();
      a = 4'b0100; cyc();
      chk("pre_rst_flags", 32'(flags8), 32'h4);
      chk("pre_rst_ack", 32'(ack8), 1);
      rn = 0; cyc();
      chk("mid_rst_flags", 32'(flags8), 0);
      chk("mid_rst_ack", 32'(ack8), 0);
      chk("mid_rst_cnt", 32'(cnt8), 0);
      rn = 1; a = 4'h0; cyc();
      chk("re_accept_ack", 32'(ack8), 1);
      req = 0; cyc();
      chk("re_drop_ack", 32'(ack8), 0);
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
